// File: rtl/handshake_pkg.sv
// Shared constants for the valid/ready register slice: state codes and default payload width.
// The state codes double as the occupancy output encoding.
package handshake_pkg;

   localparam int DEFAULT_WORD_WIDTH = 8;

   // Each state code equals the number of words held.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/handshake_en_reg.sv
// Payload register with load enable and synchronous active-low clear.
// Used as both the output register and the skid register of the slice.
module handshake_en_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n)    data_q <= '0;
      else if (en_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/handshake_skid_ready_slice.sv
// Full valid/ready register slice: all outputs come from flops, and a one-entry skid
// register catches the word accepted in the cycle before registered up_ready falls.
module handshake_skid_ready_slice
   import handshake_pkg::*;
#(
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  up_valid,
   input  logic [WORD_WIDTH-1:0] up_data,
   output logic                  up_ready,
   output logic                  down_valid,
   output logic [WORD_WIDTH-1:0] down_data,
   input  logic                  down_ready,
   output logic [1:0]            occupancy
);

   logic [1:0]            state_q, state_d;
   logic                  up_ready_q;
   logic                  down_valid_q;
   logic                  out_load, skid_load;
   logic [WORD_WIDTH-1:0] out_d;
   logic [WORD_WIDTH-1:0] skid_q;
   logic                  ins, rem;

   assign ins = up_valid & up_ready_q;
   assign rem = down_valid_q & down_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      out_load  = 1'b0;
      skid_load = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (ins) begin
               out_load = 1'b1;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (ins && rem) begin
               out_load = 1'b1;
            end else if (ins) begin
               skid_load = 1'b1;
               state_d   = ST_FULL;
            end else if (rem) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (rem) begin
               out_load = 1'b1;
               state_d  = ST_BUSY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // In FULL the output register refills from the skid; otherwise from upstream.
   assign out_d = (state_q == ST_FULL) ? skid_q : up_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         up_ready_q   <= 1'b0;
         down_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         up_ready_q   <= (state_d != ST_FULL);
         down_valid_q <= (state_d != ST_EMPTY);
      end
   end

   handshake_en_reg #(.WIDTH(WORD_WIDTH)) u_out_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (out_load),
      .d_i   (out_d),
      .q_o   (down_data)
   );

   handshake_en_reg #(.WIDTH(WORD_WIDTH)) u_skid_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (skid_load),
      .d_i   (up_data),
      .q_o   (skid_q)
   );

   assign up_ready   = up_ready_q;
   assign down_valid = down_valid_q;
   assign occupancy  = state_q;

endmodule

// File: tb/tb_handshake_skid_ready_slice.sv
// Self-checking bench for handshake_skid_ready_slice: directed scenarios plus random data,
// compared against a queue-based model of a two-word FIFO with registered ready.
module tb_handshake_skid_ready_slice;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       up_valid;
   logic [7:0] up_data;
   logic       up_ready;
   logic       down_valid;
   logic [7:0] down_data;
   logic       down_ready;
   logic [1:0] occupancy;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: held words in arrival order, plus the registered ready bit.
   logic [7:0] mq[$];
   logic       m_ready = 1'b0;

   // Handshakes observed at the DUT boundary, for order/loss/duplication checks.
   logic [7:0] sent[$];
   logic [7:0] got[$];

   handshake_skid_ready_slice #(.WORD_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_ready   (up_ready),
      .down_valid (down_valid),
      .down_data  (down_data),
      .down_ready (down_ready),
      .occupancy  (occupancy)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model across the edge, return at the falling edge.
   task automatic cycle(input logic rn, input logic uv, input logic [7:0] ud, input logic dr);
      logic m_ins, m_rem;
      rst_n      = rn;
      up_valid   = uv;
      up_data    = ud;
      down_ready = dr;
      if (rn && uv && up_ready === 1'b1)   sent.push_back(ud);
      if (rn && dr && down_valid === 1'b1) got.push_back(down_data);
      @(posedge clk);
      if (!rn) begin
         mq.delete();
         m_ready = 1'b0;
      end else begin
         m_ins = uv && m_ready;
         m_rem = (mq.size() != 0) && dr;
         if (m_rem) void'(mq.pop_front());
         if (m_ins) mq.push_back(ud);
         m_ready = (mq.size() != 2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b1, 8'hEE, 1'b1);
         n_cmp++;
         if (up_ready !== 1'b0 || down_valid !== 1'b0 || occupancy !== 2'd0 || down_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got ready=%b valid=%b occ=%0d data=%h, want 0 0 0 00",
                     i, up_ready, down_valid, occupancy, down_data);
         end
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (up_ready !== 1'b1 || down_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%b valid=%b occ=%0d, want 1 0 0",
                  up_ready, down_valid, occupancy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words[3];
      words = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, words[i], 1'b1);
         n_cmp++;
         if (down_valid !== 1'b1 || down_data !== words[i] || occupancy !== 2'd1 || up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got valid=%b data=%h occ=%0d ready=%b, want 1 %h 1 1",
                     i, down_valid, down_data, occupancy, up_ready, words[i]);
         end
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (down_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL b2b_drain: got valid=%b occ=%0d, want 0 0", down_valid, occupancy);
      end
   endtask

   task automatic test_full_drain();
      cycle(1'b1, 1'b1, 8'hA5, 1'b0);
      cycle(1'b1, 1'b1, 8'h5A, 1'b0);
      n_cmp++;
      if (occupancy !== 2'd2 || up_ready !== 1'b0 || down_data !== 8'hA5 || down_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full: got occ=%0d ready=%b data=%h valid=%b, want 2 0 a5 1",
                  occupancy, up_ready, down_data, down_valid);
      end
      // Upstream keeps offering a word that must be refused while FULL.
      cycle(1'b1, 1'b1, 8'h77, 1'b0);
      n_cmp++;
      if (occupancy !== 2'd2 || up_ready !== 1'b0 || down_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL full_hold: got occ=%0d ready=%b data=%h, want 2 0 a5",
                  occupancy, up_ready, down_data);
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (occupancy !== 2'd1 || up_ready !== 1'b1 || down_data !== 8'h5A || down_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_one: got occ=%0d ready=%b data=%h valid=%b, want 1 1 5a 1",
                  occupancy, up_ready, down_data, down_valid);
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (occupancy !== 2'd0 || down_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_all: got occ=%0d valid=%b, want 0 0", occupancy, down_valid);
      end
   endtask

   task automatic test_toggle_random();
      sent.delete();
      got.delete();
      for (int i = 0; i < 48; i++) begin
         cycle(1'b1, 1'b1, 8'($urandom), (i % 2) == 0);
         n_cmp++;
         if (up_ready !== m_ready || down_valid !== (mq.size() != 0) || occupancy !== 2'(mq.size())
             || (mq.size() != 0 && down_data !== mq[0])) begin
            n_fail++;
            $display("FAIL toggle_model[%0d]: got ready=%b valid=%b occ=%0d data=%h, want %b %b %0d %h",
                     i, up_ready, down_valid, occupancy, down_data, m_ready, mq.size() != 0,
                     mq.size(), (mq.size() != 0) ? mq[0] : 8'h00);
         end
         n_cmp++;
         if (occupancy < 2'd2 && up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_ready[%0d]: got ready=%b with occ=%0d, want 1", i, up_ready, occupancy);
         end
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (got.size() != sent.size() || sent.size() == 0) begin
         n_fail++;
         $display("FAIL toggle_count: got %0d words received, want %0d sent", got.size(), sent.size());
      end else begin
         for (int i = 0; i < sent.size(); i++) begin
            n_cmp++;
            if (got[i] !== sent[i]) begin
               n_fail++;
               $display("FAIL toggle_order[%0d]: got %h, want %h", i, got[i], sent[i]);
            end
         end
      end
   endtask

   task automatic test_reset_while_full();
      cycle(1'b1, 1'b1, 8'h01, 1'b0);
      cycle(1'b1, 1'b1, 8'h02, 1'b0);
      n_cmp++;
      if (occupancy !== 2'd2) begin
         n_fail++;
         $display("FAIL rst_full_setup: got occ=%0d, want 2", occupancy);
      end
      cycle(1'b0, 1'b1, 8'h03, 1'b1);
      n_cmp++;
      if (up_ready !== 1'b0 || down_valid !== 1'b0 || occupancy !== 2'd0 || down_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_full: got ready=%b valid=%b occ=%0d data=%h, want 0 0 0 00",
                  up_ready, down_valid, occupancy, down_data);
      end
      got.delete();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 8'h00, 1'b1);
         n_cmp++;
         if (down_valid !== 1'b0 || occupancy !== 2'd0 || up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_full_after[%0d]: got valid=%b occ=%0d ready=%b, want 0 0 1",
                     i, down_valid, occupancy, up_ready);
         end
      end
      n_cmp++;
      if (got.size() != 0) begin
         n_fail++;
         $display("FAIL rst_full_leak: got %0d words downstream, want 0", got.size());
      end
   endtask

   task automatic test_gaps();
      logic pattern[8];
      pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      sent.delete();
      got.delete();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, pattern[i], 8'(8'h40 + i), 1'b1);
         n_cmp++;
         if (down_valid !== pattern[i] || occupancy !== {1'b0, pattern[i]}
             || (pattern[i] && down_data !== 8'(8'h40 + i))) begin
            n_fail++;
            $display("FAIL gaps[%0d]: got valid=%b occ=%0d data=%h, want %b %0d %h",
                     i, down_valid, occupancy, down_data, pattern[i], pattern[i], 8'(8'h40 + i));
         end
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (got.size() != 4 || got[0] !== 8'h40 || got[1] !== 8'h43 || got[2] !== 8'h44 || got[3] !== 8'h47) begin
         n_fail++;
         $display("FAIL gaps_order: got %0d words (%p), want 40 43 44 47", got.size(), got);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      up_valid   = 1'b0;
      up_data    = 8'h00;
      down_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_full_drain();
      test_toggle_random();
      test_reset_while_full();
      test_gaps();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
